lsu_ctrl: RTL and testbench

Load/store unit controller: the initiator side of the data-memory port. It accepts one load or store request at a time from the MEM stage over a valid/ready handshake and checks alignment and address range. It drives the synchronous-read byte-addressed data memory (addr/wdata/wr_en/rd_en/mem_op in, rdata out), holds the request stable across the memory's one-cycle read latency, and returns the result or exception over a valid/ready response channel.

---
 rtl/lsu_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller, initiator side of the data-memory port.
// Accepts one load/store at a time, checks alignment and range, drives a
// synchronous-read byte-addressed dmem and returns data or an exception.
`timescale 1ns/1ps

module lsu_ctrl #(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_mem_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_is_load,
    output logic            resp_err,
    output logic [1:0]      resp_cause,
    output logic [XLEN-1:0] resp_addr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr_en,
    output logic            mem_rd_en,
    output logic [2:0]      mem_op,
    input  logic [XLEN-1:0] mem_rdata
);

    // Memory operation encoding shared with the data memory.
    localparam logic [2:0] LP_MEM_BYTE   = 3'd0;
    localparam logic [2:0] LP_MEM_HALF   = 3'd1;
    localparam logic [2:0] LP_MEM_WORD   = 3'd2;
    localparam logic [2:0] LP_MEM_BYTE_U = 3'd3;
    localparam logic [2:0] LP_MEM_HALF_U = 3'd4;

    // Controller states.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_CAPT  = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    // Exception cause codes.
    localparam logic [1:0] LP_CAUSE_NONE   = 2'b00;
    localparam logic [1:0] LP_CAUSE_LD_MIS = 2'b01;
    localparam logic [1:0] LP_CAUSE_ST_MIS = 2'b10;
    localparam logic [1:0] LP_CAUSE_FAULT  = 2'b11;

    // One bit wider than the address so the limit itself is representable.
    localparam logic [XLEN:0] LP_MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    // Extend the low bytes of a read word according to the access size.
    // The dmem may already deliver extended data; re-extending is idempotent.
    function automatic logic [XLEN-1:0] f_extend(input logic [2:0] op,
                                                 input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] res;
        res = {XLEN{1'b0}};
        case (op)
            LP_MEM_BYTE:   res = {{(XLEN-8){raw[7]}}, raw[7:0]};
            LP_MEM_BYTE_U: res = {{(XLEN-8){1'b0}}, raw[7:0]};
            LP_MEM_HALF:   res = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LP_MEM_HALF_U: res = {{(XLEN-16){1'b0}}, raw[15:0]};
            LP_MEM_WORD:   res = raw;
            default:       res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    logic [2:0]      r_state;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_rdata;
    logic [4:0]      r_resp_rd;
    logic            r_resp_is_load;
    logic            r_resp_err;
    logic [1:0]      r_resp_cause;
    logic [XLEN-1:0] r_resp_addr;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_mem_wr_en;
    logic            r_mem_rd_en;
    logic [2:0]      r_mem_op;

    logic            w_accept;
    logic            w_misaligned;
    logic            w_op_illegal;
    logic            w_out_of_range;
    logic            w_fault;
    logic            w_err;
    logic [1:0]      w_cause;
    logic [XLEN-1:0] w_load_data;

    // Alignment check: halves need an even address, words a multiple of four.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_mem_op)
            LP_MEM_HALF, LP_MEM_HALF_U: w_misaligned = req_addr[0];
            LP_MEM_WORD:                w_misaligned = (req_addr[1:0] != 2'b00);
            default:                    w_misaligned = 1'b0;
        endcase
    end

    // Access-fault check: out of range, unsigned store sizes, or unknown op.
    always_comb begin
        w_op_illegal   = (req_mem_op > LP_MEM_HALF_U);
        w_out_of_range = ({1'b0, req_addr} >= LP_MEM_LIMIT);
        if (req_is_store) begin
            w_fault = w_out_of_range | w_op_illegal |
                      (req_mem_op == LP_MEM_BYTE_U) | (req_mem_op == LP_MEM_HALF_U);
        end else begin
            w_fault = w_out_of_range | w_op_illegal;
        end
    end

    // Cause selection: misalignment outranks access fault.
    always_comb begin
        w_err   = w_misaligned | w_fault;
        w_cause = LP_CAUSE_NONE;
        if (w_misaligned) begin
            w_cause = req_is_store ? LP_CAUSE_ST_MIS : LP_CAUSE_LD_MIS;
        end else if (w_fault) begin
            w_cause = LP_CAUSE_FAULT;
        end else begin
            w_cause = LP_CAUSE_NONE;
        end
    end

    // Acceptance only from IDLE and never in a flush cycle.
    always_comb begin
        w_accept    = (r_state == S_IDLE) & req_valid & ~flush;
        w_load_data = f_extend(r_mem_op, mem_rdata);
    end

    // Main controller: state, memory-side drive and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= {XLEN{1'b0}};
            r_resp_rd      <= 5'd0;
            r_resp_is_load <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_cause   <= LP_CAUSE_NONE;
            r_resp_addr    <= {XLEN{1'b0}};
            r_mem_addr     <= {XLEN{1'b0}};
            r_mem_wdata    <= {XLEN{1'b0}};
            r_mem_wr_en    <= 1'b0;
            r_mem_rd_en    <= 1'b0;
            r_mem_op       <= LP_MEM_BYTE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Tag, address and kind are captured for every request.
                        r_resp_rd      <= req_rd;
                        r_resp_addr    <= req_addr;
                        r_resp_is_load <= ~req_is_store;
                        r_resp_cause   <= w_cause;
                        r_resp_err     <= w_err;
                        r_resp_rdata   <= {XLEN{1'b0}};
                        if (w_err) begin
                            // Errors never touch the memory.
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (req_is_store) begin
                            r_mem_addr  <= req_addr;
                            r_mem_op    <= req_mem_op;
                            r_mem_wdata <= req_wdata;
                            r_mem_wr_en <= 1'b1;
                            r_state     <= S_WR;
                        end else begin
                            r_mem_addr  <= req_addr;
                            r_mem_op    <= req_mem_op;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    // dmem latches the address this edge; keep it held.
                    if (flush) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_RD_CAPT;
                    end
                end
                S_RD_CAPT: begin
                    r_mem_rd_en <= 1'b0;
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WR: begin
                    // The write commits on this edge regardless of flush.
                    r_mem_wr_en <= 1'b0;
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush || resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_rd_en  <= 1'b0;
                    r_mem_wr_en  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_rd      = r_resp_rd;
    assign resp_is_load = r_resp_is_load;
    assign resp_err     = r_resp_err;
    assign resp_cause   = r_resp_cause;
    assign resp_addr    = r_resp_addr;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_rd_en    = r_mem_rd_en;
    assign mem_op       = r_mem_op;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed plus randomized bench for lsu_ctrl with a behavioural
// data memory and a byte-array reference model.
`timescale 1ns/1ps

module tb_lsu_ctrl;

    localparam int MB = 1024;
    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_H  = 3'd1;
    localparam logic [2:0] OP_W  = 3'd2;
    localparam logic [2:0] OP_BU = 3'd3;
    localparam logic [2:0] OP_HU = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready, req_is_store;
    logic [2:0]  req_mem_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_is_load, resp_err;
    logic [31:0] resp_rdata, resp_addr;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_cause;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en, mem_rd_en;
    logic [2:0]  mem_op;
    logic        mem_init;

    logic [7:0]  dmem    [0:MB-1];
    logic [7:0]  ref_mem [0:MB-1];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_mem_op(req_mem_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_err(resp_err),
        .resp_cause(resp_cause), .resp_addr(resp_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_op(mem_op), .mem_rdata(mem_rdata)
    );

    // Data memory read path: bytes picked at the address, extended per op.
    function automatic logic [31:0] dmem_rd(input logic [31:0] a, input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = dmem[a];
        h = {dmem[a+1], dmem[a]};
        case (op)
            OP_B:    return {{24{b[7]}}, b};
            OP_BU:   return {24'd0, b};
            OP_H:    return {{16{h[15]}}, h};
            OP_HU:   return {16'd0, h};
            default: return {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
        endcase
    endfunction

    // Synchronous-read, byte-addressed data memory.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MB; i++) dmem[i] <= 8'(i * 37 + 5);
        end else begin
            if (mem_wr_en) begin
                case (mem_op)
                    OP_B, OP_BU: dmem[mem_addr] <= mem_wdata[7:0];
                    OP_H, OP_HU: begin
                        dmem[mem_addr]   <= mem_wdata[7:0];
                        dmem[mem_addr+1] <= mem_wdata[15:8];
                    end
                    default: begin
                        dmem[mem_addr]   <= mem_wdata[7:0];
                        dmem[mem_addr+1] <= mem_wdata[15:8];
                        dmem[mem_addr+2] <= mem_wdata[23:16];
                        dmem[mem_addr+3] <= mem_wdata[31:24];
                    end
                endcase
            end
            if (mem_rd_en) mem_rdata <= dmem_rd(mem_addr, mem_op);
        end
    end

    // Reference load: numeric value of little-endian bytes, signed where asked.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
        longint v;
        int n;
        n = (op == OP_W) ? 4 : ((op == OP_H || op == OP_HU) ? 2 : 1);
        v = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[a + k]);
        if (op == OP_B  && v >= 128)   v = v - 256;
        if (op == OP_H  && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] wd);
        int n;
        longint v;
        n = (op == OP_W) ? 4 : ((op == OP_H) ? 2 : 1);
        v = longint'(wd);
        for (int k = 0; k < n; k++) begin
            ref_mem[a + k] = 8'(v % 256);
            v = v / 256;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with response hold-off of 'hold' cycles.
    task automatic do_req(input logic st, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int hold,
                          output logic [31:0] got);
        logic        mis, flt, e, saw_rd, both;
        logic [1:0]  cause;
        logic [31:0] exp_data;
        int          exp_lat, lat, wr_cnt;
        mis = ((op == OP_H || op == OP_HU) && (a % 2 != 0)) || (op == OP_W && (a % 4 != 0));
        flt = (a >= MB) || (st && (op == OP_BU || op == OP_HU));
        e = mis | flt;
        cause = mis ? (st ? 2'd2 : 2'd1) : (flt ? 2'd3 : 2'd0);
        exp_data = (!e && !st) ? ref_load(a, op) : 32'd0;
        if (!e && st) ref_store(a, op, wd);
        exp_lat = e ? 0 : (st ? 1 : 2);

        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_mem_op = op;
        req_addr = a; req_wdata = wd; req_rd = rd;
        step();
        req_valid = 1'b0;
        lat = 0; wr_cnt = 0; saw_rd = 1'b0; both = 1'b0;
        while (resp_valid !== 1'b1 && lat < 10) begin
            if (mem_rd_en) saw_rd = 1'b1;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en && mem_wr_en) both = 1'b1;
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rd_en_seen", 32'(saw_rd), 32'(!e && !st));
        chk("wr_cycles", 32'(wr_cnt), (!e && st) ? 32'd1 : 32'd0);
        chk("rd_wr_both", 32'(both), 32'd0);
        chk("resp_err", 32'(resp_err), 32'(e));
        chk("resp_cause", 32'(resp_cause), 32'(cause));
        chk("resp_rdata", resp_rdata, exp_data);
        chk("resp_rd", 32'(resp_rd), 32'(rd));
        chk("resp_is_load", 32'(resp_is_load), 32'(!st));
        chk("resp_addr", resp_addr, a);
        chk("resp_en_off", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        got = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, exp_data);
            chk("hold_cause", 32'(resp_cause), 32'(cause));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("post_hs_valid", 32'(resp_valid), 32'd0);
        chk("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got, a;
        logic [2:0]  op;
        logic        st;
        for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst_n = 1'b0; mem_init = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_is_store = 1'b0; req_mem_op = OP_B; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        chk("rst_mem_op", 32'(mem_op), 32'(OP_B));
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        mem_init = 1'b0;
        rst_n = 1'b1;
        step();

        // Directed basic traffic.
        do_req(1'b1, OP_W, 32'h80, 32'hDEADBEEF, 5'd3, 0, got);
        do_req(1'b0, OP_W, 32'h80, 32'd0, 5'd9, 0, got);
        chk("lw80_const", got, 32'hDEADBEEF);
        do_req(1'b0, OP_B, 32'h83, 32'd0, 5'd1, 0, got);
        chk("lb83_const", got, 32'hFFFFFFDE);
        do_req(1'b0, OP_BU, 32'h83, 32'd0, 5'd2, 0, got);
        chk("lbu83_const", got, 32'h000000DE);
        do_req(1'b0, OP_H, 32'h82, 32'd0, 5'd4, 0, got);
        chk("lh82_const", got, 32'hFFFFDEAD);
        do_req(1'b0, OP_HU, 32'h80, 32'd0, 5'd5, 0, got);
        chk("lhu80_const", got, 32'h0000BEEF);
        do_req(1'b1, OP_B, 32'h81, 32'h11, 5'd6, 0, got);
        do_req(1'b0, OP_W, 32'h80, 32'd0, 5'd7, 0, got);
        chk("lw80_after_sb", got, 32'hDEAD11EF);
        do_req(1'b0, OP_W, 32'h82, 32'd0, 5'd8, 0, got);
        do_req(1'b1, OP_H, 32'h81, 32'h5555, 5'd10, 0, got);
        do_req(1'b0, OP_W, 32'h80, 32'd0, 5'd11, 0, got);
        chk("lw80_unchanged", got, 32'hDEAD11EF);
        do_req(1'b0, OP_W, 32'(MB), 32'd0, 5'd12, 0, got);
        do_req(1'b1, OP_BU, 32'h40, 32'hAA, 5'd13, 0, got);
        do_req(1'b0, OP_W, 32'h80, 32'd0, 5'd14, 5, got);

        // Flush while idle: no acceptance.
        req_valid = 1'b1; req_is_store = 1'b0; req_mem_op = OP_W; req_addr = 32'h80; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_ready", 32'(req_ready), 32'd1);
        chk("fl_idle_rd_en", 32'(mem_rd_en), 32'd0);

        // Flush in RD_CAPT: no response.
        req_valid = 1'b1; req_is_store = 1'b0; req_mem_op = OP_W; req_addr = 32'h80; req_rd = 5'd15;
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_capt_valid", 32'(resp_valid), 32'd0);
        chk("fl_capt_ready", 32'(req_ready), 32'd1);
        chk("fl_capt_rd_en", 32'(mem_rd_en), 32'd0);
        step();
        chk("fl_capt_valid2", 32'(resp_valid), 32'd0);

        // Flush in WR: write commits, no response.
        req_valid = 1'b1; req_is_store = 1'b1; req_mem_op = OP_W; req_addr = 32'h104;
        req_wdata = 32'h12345678;
        step();
        req_valid = 1'b0;
        chk("fl_wr_en", 32'(mem_wr_en), 32'd1);
        ref_store(32'h104, OP_W, 32'h12345678);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_wr_valid", 32'(resp_valid), 32'd0);
        chk("fl_wr_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, OP_W, 32'h104, 32'd0, 5'd16, 0, got);

        // Flush in RESP: response dropped.
        req_valid = 1'b1; req_is_store = 1'b0; req_mem_op = OP_W; req_addr = 32'h82;
        step();
        req_valid = 1'b0;
        chk("fl_resp_pre", 32'(resp_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_resp_valid", 32'(resp_valid), 32'd0);
        chk("fl_resp_ready", 32'(req_ready), 32'd1);

        // Reset during RD_ISSUE.
        req_valid = 1'b1; req_is_store = 1'b0; req_mem_op = OP_W; req_addr = 32'h80;
        step();
        req_valid = 1'b0;
        chk("mid_rd_en_pre", 32'(mem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        do_req(1'b0, OP_W, 32'h80, 32'd0, 5'd17, 0, got);
        chk("lw80_post_rst", got, 32'hDEAD11EF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            st = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) a = 32'(MB + $urandom_range(0, 63));
            else a = 32'($urandom_range(0, MB - 1));
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            do_req(st, op, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2), got);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
